// File: rtl/axi_ddc_depack.sv
// DDC accumulation depacketiser: collects N_CH I/Q beats per frame into ping-pong
// buffers and streams each stored frame as a header word followed by I/Q words.
module axi_ddc_depack #(
    parameter int          N_CH        = 4,
    parameter logic [15:0] FRAME_MAGIC = 16'hDDC0
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic [95:0] s_axis_ddc_tdata,
    input  logic        s_axis_ddc_tvalid,
    output logic        s_axis_ddc_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic        clr,
    output logic [15:0] drop_cnt,
    output logic [15:0] err_cnt,
    output logic        overflow
);

    localparam int             BW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [BW-1:0]  LAST = BW'(N_CH - 1);
    localparam logic [7:0]     NCH8 = 8'(N_CH);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_I, S_Q} tx_state_t;

    logic [95:0]   r_buf [2][N_CH];
    logic [31:0]   r_snap [2];
    logic [BW-1:0] r_beat;
    logic [BW-1:0] r_ch;
    logic [1:0]    r_full;
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic          r_dropping;
    logic [31:0]   r_frame_cnt;
    logic [15:0]   r_drop_cnt;
    logic [15:0]   r_err_cnt;
    logic          r_overflow;
    tx_state_t     r_state;
    logic [63:0]   r_tdata;
    logic          r_tvalid;
    logic          r_tlast;

    logic          w_drop;
    logic          w_complete;
    logic          w_store;
    logic          w_hs;
    logic          w_rd_done;
    logic          w_next_full;
    logic [1:0]    w_set_mask;
    logic [1:0]    w_clr_mask;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [63:0] sext48(input logic [47:0] v);
        return {{16{v[47]}}, v};
    endfunction

    function automatic logic [63:0] hdr_word(input logic [31:0] fc);
        return {FRAME_MAGIC, 8'd0, NCH8, fc};
    endfunction

    // A frame is dropped as a whole when its first beat finds the write buffer occupied.
    assign w_drop      = (r_beat == '0) ? r_full[r_wr_ptr] : r_dropping;
    assign w_complete  = s_axis_ddc_tvalid && (r_beat == LAST);
    assign w_store     = w_complete && !w_drop;
    assign w_hs        = r_tvalid && m_axis_tready;
    assign w_rd_done   = w_hs && (r_state == S_Q) && (r_ch == LAST);
    assign w_next_full = r_full[~r_rd_ptr];
    assign w_set_mask  = w_store   ? (2'b01 << r_wr_ptr) : 2'b00;
    assign w_clr_mask  = w_rd_done ? (2'b01 << r_rd_ptr) : 2'b00;

    assign s_axis_ddc_tready = 1'b1;
    assign m_axis_tdata      = r_tdata;
    assign m_axis_tvalid     = r_tvalid;
    assign m_axis_tlast      = r_tlast;
    assign drop_cnt          = r_drop_cnt;
    assign err_cnt           = r_err_cnt;
    assign overflow          = r_overflow;

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_ddc_tvalid && !w_drop)
            r_buf[r_wr_ptr][r_beat] <= s_axis_ddc_tdata;
        if (w_store)
            r_snap[r_wr_ptr] <= r_frame_cnt;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_beat      <= '0;
            r_full      <= 2'b00;
            r_wr_ptr    <= 1'b0;
            r_dropping  <= 1'b0;
            r_frame_cnt <= 32'd0;
            r_drop_cnt  <= 16'd0;
            r_err_cnt   <= 16'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_full <= (r_full & ~w_clr_mask) | w_set_mask;
            if (w_store)
                r_wr_ptr <= ~r_wr_ptr;
            if (s_axis_ddc_tvalid) begin
                if (r_beat == '0 && r_full[r_wr_ptr]) begin
                    r_drop_cnt <= sat_inc(r_drop_cnt);
                    r_overflow <= 1'b1;
                end
                if (w_complete) begin
                    r_beat      <= '0;
                    r_dropping  <= 1'b0;
                    r_frame_cnt <= r_frame_cnt + 32'd1;
                end else begin
                    r_beat     <= r_beat + BW'(1);
                    r_dropping <= w_drop;
                end
            end else if (r_beat != '0) begin
                r_beat     <= '0;
                r_dropping <= 1'b0;
                r_err_cnt  <= sat_inc(r_err_cnt);
            end
            if (clr) begin
                r_drop_cnt <= 16'd0;
                r_err_cnt  <= 16'd0;
                r_overflow <= 1'b0;
            end
        end
    end

    // Output registers advance only on a handshake, so a stalled word holds steady.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state  <= S_IDLE;
            r_tdata  <= 64'd0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_ch     <= '0;
            r_rd_ptr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rd_ptr]) begin
                        r_state  <= S_HDR;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                        r_ch     <= '0;
                        r_tdata  <= hdr_word(r_snap[r_rd_ptr]);
                    end
                end
                S_HDR: begin
                    if (w_hs) begin
                        r_state <= S_I;
                        r_tdata <= sext48(r_buf[r_rd_ptr][0][47:0]);
                    end
                end
                S_I: begin
                    if (w_hs) begin
                        r_state <= S_Q;
                        r_tdata <= sext48(r_buf[r_rd_ptr][r_ch][95:48]);
                        r_tlast <= (r_ch == LAST);
                    end
                end
                S_Q: begin
                    if (w_hs) begin
                        r_tlast <= 1'b0;
                        if (r_ch != LAST) begin
                            r_state <= S_I;
                            r_ch    <= r_ch + BW'(1);
                            r_tdata <= sext48(r_buf[r_rd_ptr][r_ch + BW'(1)][47:0]);
                        end else begin
                            r_rd_ptr <= ~r_rd_ptr;
                            r_ch     <= '0;
                            // Chain straight into the other buffer's packet to avoid a bubble.
                            if (w_next_full) begin
                                r_state <= S_HDR;
                                r_tdata <= hdr_word(r_snap[~r_rd_ptr]);
                            end else begin
                                r_state  <= S_IDLE;
                                r_tvalid <= 1'b0;
                                r_tdata  <= 64'd0;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ddc_depack.sv
// Self-checking bench for axi_ddc_depack: random I/Q frames against a packet-level
// reference model, plus directed overflow, gap, stall, reset and clear scenarios.
module tb_axi_ddc_depack;

    localparam int          N_CH  = 4;
    localparam logic [15:0] MAGIC = 16'hDDC0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        clr;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int stall_err = 0;
    int mode = 1;
    int mdl_fc;
    int mdl_err;

    logic [64:0]        mon_q[$];
    logic [64:0]        exp_q[$];
    logic signed [47:0] f_i[N_CH];
    logic signed [47:0] f_q[N_CH];

    always #5 clk = ~clk;

    axi_ddc_depack #(.N_CH(N_CH), .FRAME_MAGIC(MAGIC)) dut (
        .s_axis_aclk       (clk),
        .s_axis_aresetn    (rst_n),
        .s_axis_ddc_tdata  (s_tdata),
        .s_axis_ddc_tvalid (s_tvalid),
        .s_axis_ddc_tready (s_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .m_axis_tlast      (m_tlast),
        .clr               (clr),
        .drop_cnt          (drop_cnt),
        .err_cnt           (err_cnt),
        .overflow          (overflow)
    );

    // Sink-side monitor: records every handshaked word and flags words that move while stalled.
    initial begin
        logic        pv;
        logic [63:0] pd;
        logic        pl;
        pv = 1'b0; pd = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) pv = 1'b0;
            else begin
                if (pv && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) stall_err++;
                if (m_tvalid && m_tready) mon_q.push_back({m_tlast, m_tdata});
                pv = m_tvalid && !m_tready;
                pd = m_tdata;
                pl = m_tlast;
            end
        end
    end

    // Sink ready pattern: 0 stalled, 1 always ready, 2 random, 3 toggling.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                2:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = ~m_tready;
            endcase
        end
    end

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_q.delete(); exp_q.delete();
        stall_err = 0; mdl_fc = 0; mdl_err = 0;
    endtask

    task automatic rand_frame();
        for (int c = 0; c < N_CH; c++) begin
            f_i[c] = 48'({$urandom(), $urandom()});
            f_q[c] = 48'({$urandom(), $urandom()});
        end
    endtask

    task automatic send_frame(input int nb, input bit clr_first);
        for (int b = 0; b < nb; b++) begin
            s_tvalid = 1'b1;
            s_tdata  = {f_q[b], f_i[b]};
            clr      = clr_first && (b == 0);
            @(posedge clk); #1;
            clr = 1'b0;
        end
        s_tvalid = 1'b0;
    endtask

    // Reference packet: header, then sign-extended I and Q per channel, tlast on the final Q.
    task automatic expect_packet(input int fc);
        logic signed [63:0] wi;
        logic signed [63:0] wq;
        exp_q.push_back({1'b0, MAGIC, 8'd0, 8'(N_CH), 32'(fc)});
        for (int c = 0; c < N_CH; c++) begin
            wi = f_i[c];
            wq = f_q[c];
            exp_q.push_back({1'b0, wi});
            exp_q.push_back({(c == N_CH - 1), wq});
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; clr = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_out got v=%b l=%b d=%h exp 0/0/0", m_tvalid, m_tlast, m_tdata);
        end
        checks++;
        if (drop_cnt !== 16'd0 || err_cnt !== 16'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt got drop=%h err=%h ovf=%b exp 0", drop_cnt, err_cnt, overflow);
        end
        do_reset();
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL s_tready got %b exp 1", s_tready);
        end
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_valid got %b exp 0", m_tvalid);
        end
    endtask

    task automatic test_basic();
        logic [64:0] g;
        logic [63:0] t;
        do_reset();
        mode = 1; m_tready = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            f_i[c] = 48'(c + 1);
            f_q[c] = -48'(c + 1);
        end
        exp_q.push_back({1'b0, 64'hDDC0_0004_0000_0000});
        for (int c = 0; c < N_CH; c++) begin
            t = 64'(c + 1);
            exp_q.push_back({1'b0, t});
            t = -t;
            exp_q.push_back({(c == N_CH - 1), t});
        end
        send_frame(N_CH, 1'b0);
        align();
        checks++;
        if (m_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency tvalid got %b exp 1", m_tvalid);
        end
        wait_words(9, 60);
        repeat (5) @(negedge clk);
        checks++;
        if (mon_q.size() != 9) begin
            failures++;
            $display("FAIL basic_count got %0d exp 9", mon_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < mon_q.size()) ? mon_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_word%0d got %h exp %h", i, g, exp_q[i]);
            end
        end
        align();
    endtask

    task automatic test_overflow();
        logic [64:0] g;
        int n;
        do_reset();
        mode = 0; m_tready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            if (f < 2) expect_packet(f);
            send_frame(N_CH, 1'b0);
        end
        align();
        checks++;
        if (drop_cnt !== 16'd1 || overflow !== 1'b1 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL ovf_cnt got drop=%0d ovf=%b err=%0d exp 1/1/0", drop_cnt, overflow, err_cnt);
        end
        mode = 1; m_tready = 1'b1;
        n = 0;
        while (mon_q.size() < 18 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 18) begin
            failures++;
            $display("FAIL ovf_throughput cycles got %0d exp 18", n);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (mon_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL ovf_count got %0d exp %0d", mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < mon_q.size()) ? mon_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                failures++;
                $display("FAIL ovf_word%0d got %h exp %h", i, g, exp_q[i]);
            end
        end
        align();
    endtask

    task automatic test_gap();
        logic [64:0] g;
        do_reset();
        mode = 1; m_tready = 1'b1;
        rand_frame();
        send_frame(2, 1'b0);
        align();
        checks++;
        if (err_cnt !== 16'd1) begin
            failures++;
            $display("FAIL gap_err got %0d exp 1", err_cnt);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (mon_q.size() != 0 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL gap_nopkt got words=%0d v=%b exp 0/0", mon_q.size(), m_tvalid);
        end
        align();
        rand_frame();
        expect_packet(0);
        send_frame(N_CH, 1'b0);
        wait_words(exp_q.size(), 60);
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < mon_q.size()) ? mon_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                failures++;
                $display("FAIL gap_word%0d got %h exp %h", i, g, exp_q[i]);
            end
        end
        align();
    endtask

    task automatic test_toggle();
        logic [64:0] g;
        do_reset();
        mode = 3;
        for (int f = 0; f < 2; f++) begin
            rand_frame();
            expect_packet(f);
            send_frame(N_CH, 1'b0);
        end
        wait_words(exp_q.size(), 200);
        repeat (6) @(negedge clk);
        checks++;
        if (mon_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL toggle_count got %0d exp %0d", mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < mon_q.size()) ? mon_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                failures++;
                $display("FAIL toggle_word%0d got %h exp %h", i, g, exp_q[i]);
            end
        end
        checks++;
        if (stall_err != 0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL toggle_stable got stall_err=%0d drop=%0d exp 0/0", stall_err, drop_cnt);
        end
        mode = 1;
        align();
    endtask

    task automatic test_random();
        logic [64:0] g;
        int nf;
        do_reset();
        mode = 2;
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                rand_frame();
                send_frame($urandom_range(1, N_CH - 1), 1'b0);
                align();
                mdl_err++;
            end
            nf = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                rand_frame();
                expect_packet(mdl_fc);
                mdl_fc++;
                send_frame(N_CH, 1'b0);
            end
            wait_words(exp_q.size(), 300);
            align();
        end
        checks++;
        if (mon_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count got %0d exp %0d", mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < mon_q.size()) ? mon_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_word%0d got %h exp %h", i, g, exp_q[i]);
            end
        end
        checks++;
        if (err_cnt !== 16'(mdl_err) || drop_cnt !== 16'd0 || stall_err != 0) begin
            failures++;
            $display("FAIL rand_status got err=%0d drop=%0d stall=%0d exp %0d/0/0",
                     err_cnt, drop_cnt, stall_err, mdl_err);
        end
        mode = 1;
        align();
    endtask

    task automatic test_reset_mid();
        logic [64:0] g;
        int k;
        do_reset();
        mode = 1; m_tready = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            f_i[c] = 48'(10 + c);
            f_q[c] = -48'(10 + c);
        end
        send_frame(N_CH, 1'b0);
        k = 0;
        while (!(m_tvalid && m_tdata == 64'd11) && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 40) begin
            failures++;
            $display("FAIL rstmid_reach_i1 got no I1 word exp 0x%h", 64'd11);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 64'd0) begin
            failures++;
            $display("FAIL rstmid_out got v=%b l=%b d=%h exp 0/0/0", m_tvalid, m_tlast, m_tdata);
        end
        do_reset();
        rand_frame();
        expect_packet(0);
        send_frame(N_CH, 1'b0);
        wait_words(exp_q.size(), 60);
        repeat (4) @(negedge clk);
        checks++;
        if (mon_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rstmid_count got %0d exp %0d", mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < mon_q.size()) ? mon_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                failures++;
                $display("FAIL rstmid_word%0d got %h exp %h", i, g, exp_q[i]);
            end
        end
        align();
    endtask

    task automatic test_clr();
        logic [64:0] g;
        do_reset();
        mode = 0; m_tready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            rand_frame();
            expect_packet(f);
            send_frame(N_CH, 1'b0);
        end
        rand_frame();
        send_frame(N_CH, 1'b1);
        checks++;
        if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_same_edge got drop=%0d ovf=%b exp 0/0", drop_cnt, overflow);
        end
        rand_frame();
        send_frame(N_CH, 1'b0);
        checks++;
        if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL clr_drop2 got drop=%0d ovf=%b exp 1/1", drop_cnt, overflow);
        end
        clr = 1'b1;
        align();
        clr = 1'b0;
        checks++;
        if (drop_cnt !== 16'd0 || overflow !== 1'b0 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL clr_pulse got drop=%0d ovf=%b err=%0d exp 0", drop_cnt, overflow, err_cnt);
        end
        mode = 1; m_tready = 1'b1;
        wait_words(exp_q.size(), 100);
        align();
        rand_frame();
        expect_packet(4);
        send_frame(N_CH, 1'b0);
        wait_words(exp_q.size(), 60);
        repeat (4) @(negedge clk);
        checks++;
        if (mon_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL clr_count got %0d exp %0d", mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < mon_q.size()) ? mon_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                failures++;
                $display("FAIL clr_word%0d got %h exp %h", i, g, exp_q[i]);
            end
        end
        align();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_gap();
        test_toggle();
        test_random();
        test_reset_mid();
        test_clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_ddc_depack.md
AXI_DDC_DEPACK -- requirements
Module: axi_ddc_depack

Interface
REQ-001 Parameter N_CH, default 4, sets the number of channels (beats) per accumulation frame; legal range 1..16.
REQ-002 Parameter FRAME_MAGIC, default 16'hDDC0, is the constant carried in header bits [63:48].
REQ-003 s_axis_aclk  input  1  is the single clock; all logic runs on its rising edge.
REQ-004 s_axis_aresetn  input  1  is an asynchronous, active-low reset.
REQ-005 s_axis_ddc_tdata  input  96  carries one channel's accumulation per beat: [95:48] is Q, [47:0] is I, both signed two's complement.
REQ-006 s_axis_ddc_tvalid  input  1  marks a beat; the source sends N_CH consecutive beats per frame, channel 0 first.
REQ-007 s_axis_ddc_tready  output  1  is tied to 1; the source ignores backpressure.
REQ-008 m_axis_tdata  output  64  carries packet words to the DMA.
REQ-009 m_axis_tvalid / m_axis_tready / m_axis_tlast  output / input / output  1 each  form the standard AXI4-Stream handshake; tlast marks the final word of a packet.
REQ-010 clr  input  1  is a single-cycle pulse that clears drop_cnt, err_cnt and overflow.
REQ-011 drop_cnt  output  16  counts frames dropped because no buffer was free; saturates at 16'hFFFF.
REQ-012 err_cnt  output  16  counts partial frames; saturates at 16'hFFFF.
REQ-013 overflow  output  1  is a sticky flag, set on the first drop.

Function
REQ-014 Receive side: beat_cnt counts from 0 to N_CH-1.
- A valid beat is written to the current write buffer at index beat_cnt.
- beat_cnt then increments.
- The beat at beat_cnt == N_CH-1 completes the frame and returns beat_cnt to 0.
REQ-015 Partial frame: tvalid low while 0 < beat_cnt < N_CH is a gap.
- beat_cnt resets to 0.
- Buffered beats are discarded.
- err_cnt increments.
- The write buffer stays free.
REQ-016 Buffering: two ping-pong frame buffers (A, B), each N_CH x 96 bits, each with a full flag.
- A completed frame sets its buffer's full flag.
- The write pointer then toggles to the other buffer.
REQ-017 Drop: if the write buffer is full when a frame's first beat (beat_cnt == 0) arrives, the entire frame is discarded.
- drop_cnt increments.
- overflow is set.
- The buffer contents are not modified.
REQ-018 frame_cnt (32-bit) increments on every completed frame, whether stored or dropped, so software sees gaps; it wraps from 32'hFFFFFFFF to 0.
REQ-019 Transmit FSM states are IDLE, HDR, I, Q.
- IDLE -> HDR when the read buffer is full.
- HDR -> I on handshake.
- I -> Q on handshake.
- Q -> I (next channel) on handshake if ch < N_CH-1.
- Q -> IDLE on handshake if ch == N_CH-1; this clears the read buffer's full flag and toggles the read pointer.
REQ-020 Packet length is 1+2*N_CH words.
- HDR word = {FRAME_MAGIC, 8'd0, N_CH[7:0], frame_cnt_snapshot[31:0]}.
- I word = sign-extended I[47:0] of channel ch.
- Q word = sign-extended Q[95:48] of channel ch.
- frame_cnt_snapshot is the value assigned to the frame at completion.
REQ-021 m_axis_tlast is high only on the Q word of channel N_CH-1.
REQ-022 m_axis_tdata, m_axis_tvalid and m_axis_tlast are registered.
- m_axis_tvalid first rises on the cycle after the edge that completed the frame.
REQ-023 Output stability: while tvalid is high and tready is low, tdata and tlast hold stable and tvalid stays high.
REQ-024 Throughput: with tready held high, one word is issued per cycle and consecutive packets have no idle cycle between them.
REQ-025 Simultaneous events on the same edge:
- Completion into one buffer and a packet finishing from the other: both take effect.
- Read-side full-flag clear and write-side full check on the same buffer: the check sees the pre-edge value, so the frame is dropped.
- clr and an increment on the same edge: clr wins.
REQ-026 Counter saturation: drop_cnt and err_cnt hold at 16'hFFFF.

Reset
REQ-027 Reset asserted forces the following within the same cycle, asynchronously:
- m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0;
- drop_cnt = 0, err_cnt = 0, overflow = 0;
- frame_cnt = 0, beat_cnt = 0;
- both full flags = 0, both pointers = A;
- FSM = IDLE.
REQ-028 Reset mid-packet abandons the packet with no tlast; after release, the first output is a HDR word with frame_cnt 0.
REQ-029 Buffer data RAM contents are not reset.

Verification
REQ-030 N_CH=4, beats I=1..4, Q=-1..-4, tready=1 -> 9 words follow:
- 0xDDC0_0004_00000000;
- 0x1, 0xFFFF_FFFF_FFFF_FFFF, ... 0x4, 0xFFFF_FFFF_FFFF_FFFC;
- tlast on word 9 only.
REQ-031 tready=0, three frames sent back-to-back -> frames 0 and 1 are buffered, frame 2 is dropped, drop_cnt=1, overflow=1; after tready=1, packets with headers carrying frame_cnt 0 and 1 are emitted.
REQ-032 Gap after beat 2 of 4 -> err_cnt=1 and no packet; the next full frame yields header frame_cnt 0.
REQ-033 tready toggling every cycle -> no word lost or duplicated, and tdata is stable while stalled.
REQ-034 Reset asserted during the I word of channel 1 -> outputs are 0 immediately; a frame sent after release produces a header with frame_cnt 0.
REQ-035 clr asserted on the same edge as a drop -> drop_cnt=0 and overflow=0 after that edge.
